step_dir_tx: RTL and testbench
==============================

Name: step_dir_tx

Overview:
Step/dir transmitter: turns queued motion commands (direction, step count, step period) into timed STEP/DIR pulse trains. It is the driving end of the microstepper's step/dir input. It is used in the caravel test benches in place of hand-driven step/dir registers, and is also a candidate for on-chip use, driving an external driver from the DDA path. It tracks signed absolute position and honours direction setup/hold timing.

Parameters:
COUNT_W, 16, width of the per-command step count
PERIOD_W, 16, width of the step period in clk cycles
POS_W, 32, width of the signed position counter
STEP_HIGH, 4, STEP active width in clk cycles (>=1)
DIR_SETUP, 8, cycles DIR must be stable before the first STEP edge after a direction change
DIR_HOLD, 8, cycles after the last STEP falling edge before done/idle
STEP_POL, 1, active level of STEP (0 = active-low; idle level is ~STEP_POL)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  block can accept a command (high only in IDLE)
cmd_dir  in  1  1 = forward (+1 per step), 0 = reverse
cmd_count  in  COUNT_W  number of steps
cmd_period  in  PERIOD_W  cycles from one STEP active edge to the next
abort  in  1  stop the current command early
step  out  1  step pulse output
dir  out  1  direction output
busy  out  1  command in progress
done  out  1  one-cycle pulse at command completion (normal or aborted)
position  out  POS_W  signed running position

Behaviour:
- Reset values: step = ~STEP_POL, dir = 0, cmd_ready = 1, busy = 0, done = 0, position = 0, state IDLE.
- Handshake: a command is accepted on a clk edge with cmd_valid & cmd_ready. Fields are latched on that edge. cmd_ready drops the next cycle. There is no buffering.
- FSM states and transitions:
  - IDLE: on accept, if count = 0 go to FINISH. Otherwise, if cmd_dir != dir, go to SETUP; else go to HIGH.
  - SETUP: dir updates on entry. Wait DIR_SETUP cycles, then go to HIGH.
  - HIGH: step = STEP_POL for STEP_HIGH cycles. position updates by ±1 on the cycle step goes active. Then go to LOW.
  - LOW: step idle for eff_period - STEP_HIGH cycles. eff_period = max(cmd_period, STEP_HIGH+1). When the remaining count reaches 0, go to HOLD; else go to HIGH.
  - HOLD: wait DIR_HOLD cycles, then go to FINISH.
  - FINISH: done = 1 for one cycle, then go to IDLE with cmd_ready = 1.
- Step timing: the first STEP active edge occurs 1 cycle after accept (same direction) or DIR_SETUP+1 cycles after accept (direction change).
- Period: consecutive active edges are exactly eff_period cycles apart. period = 0 or 1 is clamped.
- Zero count: no pulse, dir unchanged, done asserts 1 cycle after accept.
- Abort:
  - In SETUP: go to HOLD; no step is emitted.
  - In HIGH: the pulse completes its full STEP_HIGH width, then go to HOLD. Runt pulses are forbidden.
  - In LOW: go to HOLD immediately.
  - In IDLE, HOLD or FINISH: no effect.
- Position: arithmetic is modulo 2^POS_W (two's-complement wrap, no saturation).
- busy is high in every state except IDLE.
- Asynchronous reset mid-pulse forces step idle immediately. The command and position are discarded.
- cmd_count is unsigned. The remaining-step counter is COUNT_W bits and never underflows.

Decomposition:
- Shared package/defines (rapcore_caravel_defines): FSM state encoding (IDLE, SETUP, HIGH, LOW, HOLD, FINISH, 3 bits), and the default COUNT_W/PERIOD_W/POS_W.
- One natural sub-module: step_dir_timer. It is a loadable down-counter with a zero flag, instantiated once and shared by SETUP, HIGH, LOW and HOLD.

Test Plan:
- Same-dir command, STEP_HIGH=4, count=3, period=10 -> 3 pulses each 4 cycles wide. Active edges at accept+1, +11, +21. position = 3. done 8 cycles after the last falling edge +1. dir stays 0... set dir=1 first via a prior command.
- From dir=1, cmd_dir=0, count=2, period=20 -> dir falls the cycle after accept. First STEP edge exactly 8 cycles later. position decreases by 2.
- count=0, cmd_dir opposite -> no STEP activity, dir unchanged, done 1 cycle after accept, cmd_ready back the next cycle.
- period=1 with STEP_HIGH=4 -> edges 5 cycles apart. No pulse shorter than 4 cycles.
- abort asserted 2 cycles into the 2nd HIGH of a count=10 command -> the 2nd pulse completes at full width, no 3rd pulse, position = +2, done after DIR_HOLD.
- position preloaded near 0x7FFFFFFF (via 2^31-1 forward steps, or forced) plus 1 forward step -> wraps to 0x80000000. Async reset during HIGH -> step idle within the same cycle, all outputs at reset values.

Source files
------------

// File: rtl/step_dir_tx_pkg.sv
// Shared definitions for the step/dir transmitter: FSM encoding, default
// widths and a helper for sizing the shared interval timer.
package step_dir_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_HIGH   = 3'd2,
    ST_LOW    = 3'd3,
    ST_HOLD   = 3'd4,
    ST_FINISH = 3'd5
  } state_t;

  localparam int DEF_COUNT_W  = 16;
  localparam int DEF_PERIOD_W = 16;
  localparam int DEF_POS_W    = 32;

  // The timer must hold a full period as well as 32-bit setup/hold/width constants.
  function automatic int timer_width(input int period_w);
    return ((period_w > 31) ? period_w : 31) + 1;
  endfunction

endpackage

// File: rtl/step_dir_timer.sv
// Loadable down-counter with a zero flag. A load value of N-1 presented on
// load_i counts as the current value, so zero_o rises on the Nth cycle.
module step_dir_timer
  import step_dir_tx_pkg::*;
#(
  parameter int W = timer_width(DEF_PERIOD_W)
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_cur;

  assign cnt_cur = load_i ? load_val_i : cnt_q;
  assign zero_o  = (cnt_cur == '0);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else if (zero_o) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_cur - W'(1);
    end
  end

endmodule

// File: rtl/step_dir_tx.sv
// Step/dir transmitter: converts one motion command at a time into timed
// STEP/DIR pulse trains and tracks signed absolute position.
module step_dir_tx
  import step_dir_tx_pkg::*;
#(
  parameter int COUNT_W   = DEF_COUNT_W,
  parameter int PERIOD_W  = DEF_PERIOD_W,
  parameter int POS_W     = DEF_POS_W,
  parameter int STEP_HIGH = 4,
  parameter int DIR_SETUP = 8,
  parameter int DIR_HOLD  = 8,
  parameter bit STEP_POL  = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  // Command handshake: a command transfers on a clk edge where cmd_valid and
  // cmd_ready are both high; cmd_ready is high only while idle, no buffering.
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_dir,
  input  logic [COUNT_W-1:0]  cmd_count,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic                abort,
  output logic                step,
  output logic                dir,
  output logic                busy,
  output logic                done,
  output logic [POS_W-1:0]    position,
  output state_t              state_dbg
);

  localparam int TW = timer_width(PERIOD_W);
  localparam logic [TW-1:0] HIGH_LD  = TW'((STEP_HIGH > 0) ? STEP_HIGH - 1 : 0);
  localparam logic [TW-1:0] SETUP_LD = TW'((DIR_SETUP > 0) ? DIR_SETUP - 1 : 0);
  localparam logic [TW-1:0] HOLD_LD  = TW'((DIR_HOLD > 0) ? DIR_HOLD - 1 : 0);
  localparam logic [TW-1:0] MIN_PER  = TW'(STEP_HIGH + 1);

  state_t             state_q;
  logic               step_q;
  logic               dir_q;
  logic               busy_q;
  logic               done_q;
  logic               ready_q;
  logic               abort_q;
  logic [POS_W-1:0]   pos_q;
  logic [COUNT_W-1:0] rem_q;
  logic [TW-1:0]      low_ld_q;
  logic               tmr_load_q;
  logic [TW-1:0]      tmr_val_q;
  logic               tmr_zero;

  logic [TW-1:0]      per_ext;
  logic [TW-1:0]      low_ld_d;
  logic [POS_W-1:0]   pos_fwd;
  logic [POS_W-1:0]   pos_rev;

  // LOW lasts eff_period - STEP_HIGH cycles with eff_period clamped to STEP_HIGH+1.
  always_comb begin
    per_ext  = TW'(cmd_period);
    low_ld_d = (per_ext < MIN_PER) ? '0 : per_ext - MIN_PER;
    pos_fwd  = pos_q + POS_W'(1);
    pos_rev  = pos_q - POS_W'(1);
  end

  step_dir_timer #(
    .W (TW)
  ) u_timer (
    .clk_i      (clk),
    .reset_i    (reset),
    .load_i     (tmr_load_q),
    .load_val_i (tmr_val_q),
    .zero_o     (tmr_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      step_q     <= ~STEP_POL;
      dir_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ready_q    <= 1'b1;
      abort_q    <= 1'b0;
      pos_q      <= '0;
      rem_q      <= '0;
      low_ld_q   <= '0;
      tmr_load_q <= 1'b0;
      tmr_val_q  <= '0;
    end else begin
      done_q     <= 1'b0;
      tmr_load_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          abort_q <= 1'b0;
          if (cmd_valid && ready_q) begin
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            low_ld_q <= low_ld_d;
            rem_q    <= cmd_count;
            if (cmd_count == '0) begin
              state_q <= ST_FINISH;
              done_q  <= 1'b1;
            end else if (cmd_dir != dir_q) begin
              state_q    <= ST_SETUP;
              dir_q      <= cmd_dir;
              tmr_load_q <= 1'b1;
              tmr_val_q  <= SETUP_LD;
            end else begin
              state_q    <= ST_HIGH;
              step_q     <= STEP_POL;
              pos_q      <= cmd_dir ? pos_fwd : pos_rev;
              rem_q      <= cmd_count - COUNT_W'(1);
              tmr_load_q <= 1'b1;
              tmr_val_q  <= HIGH_LD;
            end
          end
        end
        ST_SETUP: begin
          if (abort) begin
            state_q    <= ST_HOLD;
            tmr_load_q <= 1'b1;
            tmr_val_q  <= HOLD_LD;
          end else if (tmr_zero) begin
            state_q    <= ST_HIGH;
            step_q     <= STEP_POL;
            pos_q      <= dir_q ? pos_fwd : pos_rev;
            rem_q      <= rem_q - COUNT_W'(1);
            tmr_load_q <= 1'b1;
            tmr_val_q  <= HIGH_LD;
          end
        end
        ST_HIGH: begin
          // An abort here is remembered so the pulse still gets its full width.
          if (abort) begin
            abort_q <= 1'b1;
          end
          if (tmr_zero) begin
            step_q     <= ~STEP_POL;
            tmr_load_q <= 1'b1;
            if (abort || abort_q) begin
              state_q   <= ST_HOLD;
              tmr_val_q <= HOLD_LD;
            end else begin
              state_q   <= ST_LOW;
              tmr_val_q <= (rem_q == '0) ? '0 : low_ld_q;
            end
          end
        end
        ST_LOW: begin
          if (abort || (tmr_zero && rem_q == '0)) begin
            state_q    <= ST_HOLD;
            tmr_load_q <= 1'b1;
            tmr_val_q  <= HOLD_LD;
          end else if (tmr_zero) begin
            state_q    <= ST_HIGH;
            step_q     <= STEP_POL;
            pos_q      <= dir_q ? pos_fwd : pos_rev;
            rem_q      <= rem_q - COUNT_W'(1);
            tmr_load_q <= 1'b1;
            tmr_val_q  <= HIGH_LD;
          end
        end
        ST_HOLD: begin
          if (tmr_zero) begin
            state_q <= ST_FINISH;
            done_q  <= 1'b1;
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          step_q  <= ~STEP_POL;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = ready_q;
  assign step      = step_q;
  assign dir       = dir_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign position  = pos_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_step_dir_tx.sv
// Bench for step_dir_tx: directed commands push expected STEP edges and done
// pulses into a queue; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_step_dir_tx;
  import step_dir_tx_pkg::*;

  localparam int EW = 67;
  localparam logic [1:0] EV_RISE = 2'd0;
  localparam logic [1:0] EV_FALL = 2'd1;
  localparam logic [1:0] EV_DONE = 2'd2;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main DUT: STEP_HIGH=4, DIR_SETUP=8, DIR_HOLD=8, active-high STEP
  logic        cmd_valid = 1'b0;
  logic        cmd_dir = 1'b0;
  logic [15:0] cmd_count = '0;
  logic [15:0] cmd_period = '0;
  logic        abort = 1'b0;
  logic        cmd_ready, step, dir, busy, done;
  logic [31:0] position;
  state_t      state_dbg;

  step_dir_tx dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_count(cmd_count), .cmd_period(cmd_period),
    .abort(abort), .step(step), .dir(dir), .busy(busy), .done(done),
    .position(position), .state_dbg(state_dbg)
  );

  // second DUT: 8-bit position, active-low STEP, short setup/hold
  logic        c2_valid = 1'b0;
  logic        c2_dir = 1'b0;
  logic [15:0] c2_count = '0;
  logic [15:0] c2_period = '0;
  logic        c2_abort = 1'b0;
  logic        r2, s2, d2, b2, dn2;
  logic [7:0]  p2;
  state_t      st2;

  step_dir_tx #(.POS_W(8), .STEP_POL(1'b0), .DIR_SETUP(2), .DIR_HOLD(2)) dut2 (
    .clk(clk), .reset(reset), .cmd_valid(c2_valid), .cmd_ready(r2),
    .cmd_dir(c2_dir), .cmd_count(c2_count), .cmd_period(c2_period),
    .abort(c2_abort), .step(s2), .dir(d2), .busy(b2), .done(dn2),
    .position(p2), .state_dbg(st2)
  );

  // scoreboard: {kind[1:0], dir, position[31:0], cycle[31:0]}
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  logic mon_en = 1'b1;

  function automatic void push_ev(input logic [1:0] kind, input int c,
                                  input logic [31:0] p, input logic d);
    exp_q.push_back({kind, d, p, 32'(c)});
  endfunction

  // n pulses of width 4, first rise at a+first, spaced eff, then done at a+done_off
  function automatic void expect_train(input int a, input int first, input int eff,
                                       input int n, input logic [31:0] pos0,
                                       input logic d, input int done_off);
    logic [31:0] p;
    p = pos0;
    for (int k = 0; k < n; k++) begin
      p = d ? p + 32'd1 : p - 32'd1;
      push_ev(EV_RISE, a + first + k * eff, p, d);
      push_ev(EV_FALL, a + first + k * eff + 4, 32'd0, d);
    end
    push_ev(EV_DONE, a + done_off, p, d);
  endfunction

  task automatic check_event(input logic [1:0] kind);
    logic [EW-1:0] e;
    n_checks++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_event kind=%0d at cycle %0d (nothing expected)", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      if (e[66:65] != kind || e[31:0] != 32'(cyc) ||
          (kind != EV_FALL && (e[63:32] != position || e[64] != dir))) begin
        n_fail++;
        $display("FAIL event: got kind=%0d cyc=%0d pos=%h dir=%0d, expected kind=%0d cyc=%0d pos=%h dir=%0d",
                 kind, cyc, position, dir, e[66:65], e[31:0], e[63:32], e[64]);
      end
    end
  endtask

  // monitor
  logic prev_step = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      prev_step <= 1'b0;
    end else begin
      if (mon_en) begin
        if (step && !prev_step) check_event(EV_RISE);
        if (!step && prev_step) check_event(EV_FALL);
        if (done) check_event(EV_DONE);
      end
      prev_step <= step;
    end
  end

  // active-low pulse counter for the second DUT
  int pulses2 = 0;
  logic s2_prev = 1'b1;
  always @(negedge clk) begin
    if (!s2 && s2_prev) pulses2 <= pulses2 + 1;
    s2_prev <= s2;
  end

  // driver tasks
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic start_cmd(input logic d, input int cnt, input int per, output int a);
    int t;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_ready_wait", 32'(cmd_ready), 32'd1);
    cmd_valid  = 1'b1;
    cmd_dir    = d;
    cmd_count  = 16'(cnt);
    cmd_period = 16'(per);
    a = cyc;
  endtask

  task automatic end_cmd();
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_drain: %0d events outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic u2_cmd(input int cnt, input logic [7:0] exp_pos, input string name);
    int t;
    t = 0;
    @(negedge clk);
    while (!r2 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    c2_valid = 1'b1;
    c2_dir = 1'b1;
    c2_count = 16'(cnt);
    c2_period = 16'd0;
    @(negedge clk);
    c2_valid = 1'b0;
    t = 0;
    while (!dn2 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_done"}, 32'(dn2), 32'd1);
    chk({name, "_pos"}, 32'(p2), 32'(exp_pos));
  endtask

  initial begin
    #500000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    int a;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_step", 32'(step), 32'd0);
    chk("rst_dir", 32'(dir), 32'd0);
    chk("rst_ready", 32'(cmd_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_position", position, 32'd0);
    chk("rst_state", 32'(state_dbg), 32'(ST_IDLE));
    chk("rst_step2_idle_high", 32'(s2), 32'd1);
    chk("rst_busy2", 32'(b2), 32'd0);
    chk("rst_state2", 32'(st2), 32'(ST_IDLE));
    reset = 1'b0;

    // dir 0->1, count 3, period 10: setup then rises at +9,+19,+29
    start_cmd(1'b1, 3, 10, a);
    expect_train(a, 9, 10, 3, 32'd0, 1'b1, 42);
    end_cmd();
    chk("dirchg_dir", 32'(dir), 32'd1);
    chk("dirchg_busy", 32'(busy), 32'd1);
    chk("dirchg_ready_low", 32'(cmd_ready), 32'd0);
    wait_drain("dirchg_fwd");

    // same dir, count 3, period 10: rises at +1,+11,+21
    start_cmd(1'b1, 3, 10, a);
    expect_train(a, 1, 10, 3, 32'd3, 1'b1, 34);
    end_cmd();
    wait_drain("same_dir");

    // reverse, count 2, period 20
    start_cmd(1'b0, 2, 20, a);
    expect_train(a, 9, 20, 2, 32'd6, 1'b0, 42);
    end_cmd();
    chk("rev_dir_falls", 32'(dir), 32'd0);
    wait_drain("reverse");

    // zero count with opposite dir: no pulse, dir unchanged
    start_cmd(1'b1, 0, 10, a);
    expect_train(a, 0, 0, 0, 32'd4, 1'b0, 1);
    end_cmd();
    chk("zero_busy", 32'(busy), 32'd1);
    chk("zero_ready_low", 32'(cmd_ready), 32'd0);
    wait_cyc(a + 2);
    chk("zero_ready_back", 32'(cmd_ready), 32'd1);
    chk("zero_dir_kept", 32'(dir), 32'd0);
    wait_drain("zero_count");

    // period 1 clamps to 5
    start_cmd(1'b0, 3, 1, a);
    expect_train(a, 1, 5, 3, 32'd4, 1'b0, 24);
    end_cmd();
    wait_drain("period_clamp");

    // abort 2 cycles into the 2nd HIGH: full pulse, then hold, position wraps below 0
    start_cmd(1'b0, 10, 10, a);
    expect_train(a, 1, 10, 2, 32'd1, 1'b0, 23);
    end_cmd();
    wait_cyc(a + 13);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_drain("abort_high");

    // abort in LOW goes to hold at once
    start_cmd(1'b1, 5, 10, a);
    expect_train(a, 9, 10, 1, 32'hFFFF_FFFF, 1'b1, 24);
    end_cmd();
    wait_cyc(a + 15);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_drain("abort_low");

    // abort in SETUP: no step
    start_cmd(1'b0, 5, 10, a);
    expect_train(a, 0, 0, 0, 32'd0, 1'b0, 12);
    end_cmd();
    wait_cyc(a + 3);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_drain("abort_setup");

    // async reset while STEP is active
    mon_en = 1'b0;
    start_cmd(1'b1, 4, 10, a);
    end_cmd();
    wait_cyc(a + 10);
    chk("pre_reset_step_active", 32'(step), 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("async_rst_step", 32'(step), 32'd0);
    chk("async_rst_dir", 32'(dir), 32'd0);
    chk("async_rst_position", position, 32'd0);
    chk("async_rst_ready", 32'(cmd_ready), 32'd1);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_state", 32'(state_dbg), 32'(ST_IDLE));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // single step after reset
    start_cmd(1'b1, 1, 5, a);
    expect_train(a, 9, 5, 1, 32'd0, 1'b1, 22);
    end_cmd();
    wait_drain("post_reset");

    // 8-bit position wrap on the second DUT: 127 steps then one more
    u2_cmd(127, 8'h7F, "wrap_pre");
    u2_cmd(1, 8'h80, "wrap_post");
    repeat (5) @(negedge clk);
    chk("wrap_pulse_count", 32'(pulses2), 32'd128);
    chk("wrap_dir2", 32'(d2), 32'd1);
    chk("wrap_step2_idle", 32'(s2), 32'd1);

    repeat (20) @(negedge clk);
    wait_drain("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
